// File: rtl/regfile_mp_pkg.sv
// Shared constants for the NPC register file: default data/register widths,
// the zero register/word, and a sizing helper for scoreboard arithmetic.
package regfile_mp_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam int          NREG_DEF  = 32;
    localparam int          ZERO_REG  = 0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Width that holds a counter value plus one cycle's worth of increments
    // from nports sources, without wrapping.
    function automatic int sum_width(input int cntw, input int nports);
        return cntw + $clog2(nports + 1) + 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue marks a destination busy,
// a write with wclr retires one entry, flush clears everything.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    parameter  int NISS = 2,
    parameter  int NWR  = 2,
    parameter  int CNTW = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NISS-1:0]    iss_valid,
    input  logic [NISS*AW-1:0] iss_rd,
    input  logic [NWR-1:0]     we,
    input  logic [NWR*AW-1:0]  waddr,
    input  logic [NWR-1:0]     wclr,
    input  logic               flush,
    output logic               iss_ready,
    output logic [NREG-1:0]    busy,
    output logic [NREG-1:0]    one_left
);

    localparam int            SW      = sum_width(CNTW, NISS + NWR);
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNTW) - 1);

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];
    logic [SW-1:0]   inc   [NREG];
    logic [SW-1:0]   dec   [NREG];
    logic [SW-1:0]   base  [NREG];
    logic [NREG-1:0] ovf;
    logic [NREG-1:0] unf;

    // Register 0 never accumulates: its issues and clears are ignored.
    always_comb begin
        // NOTE: every combinational output gets a value on every path before
        // any conditional update, so no latch can be inferred.
        iss_ready = 1'b1;
        ovf       = '0;
        unf       = '0;
        busy      = '0;
        one_left  = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = '0;
            dec[r]   = '0;
            base[r]  = '0;
            cnt_d[r] = cnt_q[r];
        end

        for (int r = 0; r < NREG; r++) begin
            if (r != ZERO_REG) begin
                for (int j = 0; j < NISS; j++)
                    if (iss_valid[j] && iss_rd[j*AW +: AW] == AW'(r))
                        inc[r] = inc[r] + SW'(1);
                for (int i = 0; i < NWR; i++)
                    if (we[i] && wclr[i] && waddr[i*AW +: AW] == AW'(r))
                        dec[r] = dec[r] + SW'(1);
            end
            // Clears in this cycle are deliberately not credited here.
            ovf[r] = (SW'(cnt_q[r]) + inc[r]) > CNT_MAX;
        end

        iss_ready = ~|ovf;

        for (int r = 0; r < NREG; r++) begin
            base[r] = SW'(cnt_q[r]) + (iss_ready ? inc[r] : SW'(0));
            unf[r]  = dec[r] > base[r];
            if (flush || unf[r])
                cnt_d[r] = '0;
            else
                cnt_d[r] = CNTW'(base[r] - dec[r]);
            busy[r]     = (cnt_q[r] != '0);
            one_left[r] = (cnt_q[r] == CNTW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every flop samples the pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (unf == '0)
            else $error("regfile_scoreboard: clear of a register with no pending write");
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file for the dual-issue NPC core: priority-resolved writes,
// bypassed combinational reads, debug port, commit counter and scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int NISS   = 2,
    parameter  int CNTW   = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NWR-1:0]      wclr,
    input  logic [NISS-1:0]     iss_valid,
    input  logic [NISS*AW-1:0]  iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [63:0]         wr_count
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [63:0]     wr_count_q;
    logic [63:0]     wr_count_d;

    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];
    logic [NWR-1:0]  wr_hit;
    logic [NREG-1:0] sb_busy;
    logic [NREG-1:0] sb_one_left;

    always_comb begin
        for (int k = 0; k < NRD; k++)
            ra[k] = rd_addr[k*AW +: AW];
        for (int i = 0; i < NWR; i++) begin
            wa[i]     = waddr[i*AW +: AW];
            wd[i]     = wdata[i*XLEN +: XLEN];
            wr_hit[i] = we[i] && (wa[i] != AW'(ZERO_REG));
        end
    end

    // Ascending port order: the youngest (highest-index) write lands last and wins.
    always_comb begin
        mem_d      = mem_q;
        wr_count_d = wr_count_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_hit[i]) begin
                // NOTE: blocking assignments inside always_comb let later
                // iterations override earlier ones, which encodes the priority.
                mem_d[wa[i]] = wd[i];
                wr_count_d   = wr_count_d + 64'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = mem_q[ra[k]];
            rd_busy[k]              = sb_busy[ra[k]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_hit[i] && wa[i] == ra[k])
                        rd_data[k*XLEN +: XLEN] = wd[i];
                    if (we[i] && wclr[i] && wa[i] == ra[k] && sb_one_left[ra[k]])
                        rd_busy[k] = 1'b0;
                end
            end
            if (ra[k] == AW'(ZERO_REG)) begin
                rd_data[k*XLEN +: XLEN] = XLEN'(ZERO_WORD);
                rd_busy[k]              = 1'b0;
            end
        end
    end

    assign dbg_data = mem_q[dbg_addr];
    assign wr_count = wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset entry by entry because reset-to-zero
            // contents are architecturally visible (reads and dbg_data).
            for (int r = 0; r < NREG; r++)
                mem_q[r] <= '0;
            wr_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_count_q <= wr_count_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NISS (NISS),
        .NWR  (NWR),
        .CNTW (CNTW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .wclr      (wclr),
        .flush     (flush),
        .iss_ready (iss_ready),
        .busy      (sb_busy),
        .one_left  (sb_one_left)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters; expected values
// are written by hand next to each stimulus step.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NISS = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR-1:0]      wclr;
    logic [NISS-1:0]     iss_valid;
    logic [NISS*AW-1:0]  iss_rd;
    logic                iss_ready;
    logic                flush;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic [63:0]         wr_count;

    int n_total = 0;
    int n_bad   = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we        = '0;
        waddr     = '0;
        wdata     = '0;
        wclr      = '0;
        iss_valid = '0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        idle();
        rd_addr  = '0;
        dbg_addr = '0;
        #2;
        check("rst_rd_data",   rd_data,   64'h0);
        check("rst_rd_busy",   rd_busy,   64'h0);
        check("rst_iss_ready", iss_ready, 64'h1);
        check("rst_dbg_data",  dbg_data,  64'h0);
        check("rst_wr_count",  wr_count,  64'h0);
        step();
        rst = 1'b0;

        // x5 = DEADBEEF on port 0: bypass, then array
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF};
        rd_addr = {5'd0, 5'd5};
        settle();
        check("x5_bypass", rd_data[31:0], 64'hDEAD_BEEF);
        step(); idle(); dbg_addr = 5'd5; settle();
        check("x5_read",     rd_data[31:0], 64'hDEAD_BEEF);
        check("x5_wr_count", wr_count,      64'd1);
        check("x5_dbg",      dbg_data,      64'hDEAD_BEEF);

        // write (and clear) to x0 is dropped
        we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234};
        rd_addr = {5'd0, 5'd0};
        settle();
        check("x0_bypass", rd_data[31:0], 64'h0);
        step(); idle(); dbg_addr = 5'd0; settle();
        check("x0_read",     rd_data[31:0], 64'h0);
        check("x0_wr_count", wr_count,      64'd1);
        check("x0_dbg",      dbg_data,      64'h0);

        // two ports hit x7: port 1 wins, both counted
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd0};
        settle();
        check("x7_bypass", rd_data[63:32], 64'h22);
        step(); idle(); dbg_addr = 5'd7; settle();
        check("x7_read",     rd_data[63:32], 64'h22);
        check("x7_wr_count", wr_count,       64'd3);
        check("x7_dbg",      dbg_data,       64'h22);

        // issues to x0 never mark it busy
        iss_valid = 2'b11; iss_rd = {5'd0, 5'd0};
        settle();
        check("x0_iss_ready", iss_ready, 64'h1);
        step(); idle(); rd_addr = {5'd0, 5'd0}; settle();
        check("x0_busy", rd_busy, 64'h0);

        // x3: two issues in one cycle, then one more -> count 3
        iss_valid = 2'b11; iss_rd = {5'd3, 5'd3};
        settle();
        check("x3_iss2_ready", iss_ready, 64'h1);
        step(); idle();
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd3};
        settle();
        check("x3_iss3_ready", iss_ready, 64'h1);
        step(); idle(); rd_addr = {5'd10, 5'd3}; settle();
        check("x3_busy", rd_busy, 64'h1);

        // 4th issue plus an issue to x10: all-or-none rejection
        iss_valid = 2'b11; iss_rd = {5'd10, 5'd3};
        settle();
        check("x3_iss4_ready", iss_ready, 64'h0);
        step(); idle(); settle();
        check("x10_not_busy", rd_busy, 64'h1);

        // clear in the same cycle is not credited
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd3};
        we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
        settle();
        check("x3_clr_no_credit", iss_ready, 64'h0);
        check("x3_busy_cnt3_clr", rd_busy,   64'h1);
        step(); idle(); settle();
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd3};
        settle();
        check("x3_after_clr_ready", iss_ready, 64'h1);
        step(); idle();
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd3};
        settle();
        check("x3_full_again", iss_ready, 64'h0);
        idle();
        check("x3_data", rd_data[31:0], 64'h33);
        check("x3_wr_count", wr_count, 64'd4);

        // x9: issue and clear net out
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd9};
        step(); idle();
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd9};
        we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        rd_addr = {5'd0, 5'd9};
        settle();
        check("x9_net_iss_ready", iss_ready,  64'h1);
        check("x9_net_busy_same", rd_busy[0], 64'h0);
        step(); idle(); settle();
        check("x9_busy_next", rd_busy[0],    64'h1);
        check("x9_data",      rd_data[31:0], 64'h99);
        we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        settle();
        check("x9_lone_clr_same", rd_busy[0], 64'h0);
        step(); idle(); settle();
        check("x9_lone_clr_next", rd_busy[0], 64'h0);
        check("x9_wr_count",      wr_count,   64'd6);

        // flush with a same-cycle write and a discarded issue
        iss_valid = 2'b11; iss_rd = {5'd6, 5'd4};
        step(); idle(); rd_addr = {5'd6, 5'd4}; settle();
        check("x4_x6_busy", rd_busy, 64'h3);
        flush = 1'b1;
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h55};
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd12};
        step(); idle(); settle();
        check("flush_busy_x4_x6", rd_busy,       64'h0);
        check("flush_x4_data",    rd_data[31:0], 64'h55);
        check("flush_wr_count",   wr_count,      64'd7);
        rd_addr = {5'd12, 5'd3}; settle();
        check("flush_busy_x3_x12", rd_busy, 64'h0);

        // async reset mid-stream
        iss_valid = 2'b01; iss_rd = {5'd0, 5'd5};
        step(); idle(); rd_addr = {5'd5, 5'd4}; dbg_addr = 5'd4; settle();
        check("pre_rst_busy", rd_busy, 64'h2);
        rst = 1'b1;
        settle();
        check("mid_rst_rd_data",   rd_data,   64'h0);
        check("mid_rst_rd_busy",   rd_busy,   64'h0);
        check("mid_rst_iss_ready", iss_ready, 64'h1);
        check("mid_rst_dbg",       dbg_data,  64'h0);
        check("mid_rst_wr_count",  wr_count,  64'h0);
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hAA};
        step(); idle(); rst = 1'b0; settle();
        check("rst_no_commit_dbg", dbg_data, 64'h0);
        check("rst_no_commit_cnt", wr_count, 64'h0);

        // recovery after reset
        we = 2'b10; waddr = {5'd8, 5'd0}; wdata = {32'h77, 32'h0};
        step(); idle(); rd_addr = {5'd8, 5'd0}; settle();
        check("post_rst_x8",       rd_data[63:32], 64'h77);
        check("post_rst_wr_count", wr_count,       64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
